// File: rtl/bullet_slot_scheduler.sv
// bullet_slot_scheduler: player bullet pool with fire allocation, tick-driven upward sweep and hit retirement
module bullet_slot_scheduler #(
    parameter int NUM_BULLETS = 4,
    parameter int SPRITE_W    = 32,
    parameter int BULLET_W    = 4,
    parameter int BULLET_H    = 8,
    parameter int STEP        = 4,
    parameter int TICK_BIT    = 17,
    parameter int COOLDOWN    = 8,
    parameter int IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                     clk25,
    input  logic                     rst_n,
    input  logic                     btn_fire,
    input  logic [9:0]               sprite_x,
    input  logic [9:0]               sprite_y,
    input  logic                     hit_valid,
    input  logic [IDX_W-1:0]         hit_idx,
    output logic [10*NUM_BULLETS-1:0] bullet_x,
    output logic [10*NUM_BULLETS-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]   bullet_active,
    output logic                     fire_accepted,
    output logic                     fire_dropped,
    output logic                     busy
);
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BULLETS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, SPAWN} state_t;

    state_t              state, state_nx;
    logic [TICK_BIT-1:0] tick_cnt;
    logic                tick;
    logic [CD_W-1:0]     cooldown;
    logic                fire_d, pending, rise;
    logic [IDX_W-1:0]    idx, free_idx;
    logic                any_free, hit_ok;
    logic [9:0]          spawn_x, spawn_y;
    logic [9:0]          pos_x [NUM_BULLETS];
    logic [9:0]          pos_y [NUM_BULLETS];

    assign tick    = &tick_cnt;
    assign rise    = btn_fire & ~fire_d;
    assign hit_ok  = hit_valid && (int'(hit_idx) < NUM_BULLETS);
    assign spawn_x = sprite_x + 10'(SPRITE_W / 2) - 10'(BULLET_W / 2);
    assign spawn_y = (sprite_y < 10'(BULLET_H)) ? 10'd0 : sprite_y - 10'(BULLET_H);
    assign busy    = (state != IDLE);

    genvar i;
    generate
        for (i = 0; i < NUM_BULLETS; i++) begin : g_out
            assign bullet_x[10*i +: 10] = pos_x[i];
            assign bullet_y[10*i +: 10] = pos_y[i];
        end
    endgenerate

    // Lowest-index inactive slot is the spawn target
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int s = NUM_BULLETS - 1; s >= 0; s--) begin
            if (!bullet_active[s]) begin
                free_idx = IDX_W'(s);
                any_free = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: tick beats a pending shot; sweep walks every slot once; spawn lasts one cycle
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE)  ? (tick ? SWEEP : (pending && cooldown == '0) ? SPAWN : IDLE)
                 : (state == SWEEP) ? ((idx == LAST) ? IDLE : SWEEP)
                 : IDLE;
    end

    // Tick timer, cooldown, fire edge capture, sweep index and result pulses
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt      <= '0;
            cooldown      <= '0;
            fire_d        <= 1'b0;
            pending       <= 1'b0;
            idx           <= '0;
            fire_accepted <= 1'b0;
            fire_dropped  <= 1'b0;
        end else begin
            tick_cnt      <= tick_cnt + 1'b1;
            cooldown      <= (state == SPAWN && any_free) ? CD_W'(COOLDOWN)
                           : (tick && cooldown != '0) ? cooldown - CD_W'(1) : cooldown;
            fire_d        <= btn_fire;
            pending       <= (state == SPAWN) ? rise : (pending | rise);
            idx           <= (state == SWEEP) ? idx + 1'b1 : '0;
            fire_accepted <= (state == SPAWN) && any_free;
            fire_dropped  <= (state == SPAWN) && !any_free;
        end
    end

    // Slot storage: sweep moves or retires, a hit clears active, spawn claims the free slot
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            bullet_active <= '0;
            for (int s = 0; s < NUM_BULLETS; s++) begin
                pos_x[s] <= '0;
                pos_y[s] <= '0;
            end
        end else begin
            if (state == SWEEP && bullet_active[idx]) begin
                if (pos_y[idx] < 10'(STEP)) bullet_active[idx] <= 1'b0;
                else                        pos_y[idx] <= pos_y[idx] - 10'(STEP);
            end
            if (hit_ok) bullet_active[hit_idx] <= 1'b0;
            if (state == SPAWN && any_free) begin
                pos_x[free_idx]         <= spawn_x;
                pos_y[free_idx]         <= spawn_y;
                bullet_active[free_idx] <= 1'b1;
            end
        end
    end
endmodule
